stack_sequencer: RTL and testbench

- Sequences the processor's operand stack.
- Accepts one stack command at a time (push, pop, top, add, sub) over a valid/ready handshake.
- Drives an external single-port synchronous stack RAM and maintains the stack pointer, full/empty status and the zero/sign flags consumed by conditional jumps.
- Sits between the multicycle control FSM and the stack RAM, replacing ad-hoc push/pop strobes with a single command port.

---
 rtl/stack_sequencer.sv | 174 +++++++++++++++++
 tb/tb_stack_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - operand stack sequencer driving a single-port synchronous stack RAM
module stack_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              haltN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              zero_flag,
    output logic              sign_flag,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_TOP  = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_RD_A, S_GET_A, S_GET_B, S_WR, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [ADDR_W:0]     r_sp;
    logic [2:0]          r_op;
    logic [DATA_W-1:0]   r_data, r_a, r_b, r_rsp_data;
    logic                r_rsp_err, r_zero, r_sign;
    logic                w_accept, w_err, w_full, w_binop;
    logic [DATA_W-1:0]   w_result;
    logic [ADDR_W-1:0]   w_top_addr, w_nos_addr;

    assign w_full     = (r_sp == (ADDR_W+1)'(DEPTH));
    assign w_top_addr = r_sp[ADDR_W-1:0] - ADDR_W'(1);
    assign w_nos_addr = r_sp[ADDR_W-1:0] - ADDR_W'(2);
    assign w_binop    = (r_op == OP_ADD) || (r_op == OP_SUB);
    assign w_accept   = cmd_valid && cmd_ready;

    always_comb begin
        w_err = 1'b1;
        case (cmd_op)
            OP_PUSH:        w_err = w_full;
            OP_POP, OP_TOP: w_err = (r_sp == '0);
            OP_ADD, OP_SUB: w_err = (r_sp < (ADDR_W+1)'(2));
            default:        w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_result = r_data;
        if (r_op == OP_ADD)
            w_result = r_b + r_a;
        else if (r_op == OP_SUB)
            w_result = r_b - r_a;
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    w_next = w_err ? S_DONE : ((cmd_op == OP_PUSH) ? S_WR : S_RD_A);
            end
            S_RD_A: begin
                mem_addr = w_top_addr;
                w_next   = S_GET_A;
            end
            S_GET_A: begin
                // While frozen, keep presenting the address whose data this state captures
                if (!haltN)
                    mem_addr = w_top_addr;
                else if (w_binop)
                    mem_addr = w_nos_addr;
                w_next = w_binop ? S_GET_B : S_DONE;
            end
            S_GET_B: begin
                if (!haltN)
                    mem_addr = w_nos_addr;
                w_next = S_WR;
            end
            S_WR: begin
                mem_we    = 1'b1;
                mem_addr  = (r_op == OP_PUSH) ? r_sp[ADDR_W-1:0] : w_nos_addr;
                mem_wdata = w_result;
                w_next    = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (!haltN) begin
            cmd_ready = 1'b0;
            mem_we    = 1'b0;
        end
        if (!rstN) begin
            cmd_ready = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN)
            r_state <= S_IDLE;
        else if (haltN)
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_sp       <= '0;
            r_op       <= '0;
            r_data     <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_zero     <= 1'b0;
            r_sign     <= 1'b0;
        end else if (haltN) begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op      <= cmd_op;
                    r_data    <= cmd_data;
                    r_rsp_err <= w_err;
                    if (w_err)
                        r_rsp_data <= '0;
                end
                S_GET_A: begin
                    r_a <= mem_rdata;
                    if (!w_binop)
                        r_rsp_data <= mem_rdata;
                    if (r_op == OP_POP)
                        r_sp <= r_sp - 1'b1;
                end
                S_GET_B: r_b <= mem_rdata;
                S_WR: begin
                    r_rsp_data <= w_result;
                    r_sp       <= (r_op == OP_PUSH) ? r_sp + 1'b1 : r_sp - 1'b1;
                end
                S_DONE: if (!r_rsp_err) begin
                    r_zero <= (r_rsp_data == '0);
                    r_sign <= r_rsp_data[DATA_W-1];
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (r_state == S_DONE) && haltN && rstN;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign zero_flag = r_zero;
    assign sign_flag = r_sign;
    assign count     = rstN ? r_sp : '0;
    assign empty     = (count == '0);
    assign full      = (count == (ADDR_W+1)'(DEPTH));
endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - self-checking bench for stack_sequencer against a queue-based stack model
module tb_stack_sequencer;
    logic       clk = 1'b0;
    logic       rstN, haltN, cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data, rsp_data, mem_wdata, mem_rdata;
    logic       rsp_valid, rsp_err, zero_flag, sign_flag, empty, full, mem_we;
    logic [4:0] count;
    logic [3:0] mem_addr;

    logic [7:0] ram [16];
    logic [7:0] stk [$];
    logic       m_zero, m_sign;
    logic [7:0] last_data;
    int         total = 0;
    int         bad = 0;

    stack_sequencer #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rstN(rstN), .haltN(haltN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .zero_flag(zero_flag), .sign_flag(sign_flag),
        .count(count), .empty(empty), .full(full),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] d, input int h_at, input int h_len);
        logic       e_err, ok, g_err;
        logic [7:0] e_data, a, b, wd, g_data;
        logic [3:0] e_waddr, wa;
        int         e_lat, e_wr, lat, wr_n;
        e_err = 1'b0; e_data = '0; e_waddr = '0; e_wr = 0; wa = '0; wd = '0;
        case (op)
            3'd0: if (stk.size() == 16) e_err = 1'b1;
                  else begin e_data = d; e_waddr = 4'(stk.size()); e_wr = 1; stk.push_back(d); end
            3'd1: if (stk.size() == 0) e_err = 1'b1; else e_data = stk.pop_back();
            3'd4: if (stk.size() == 0) e_err = 1'b1; else e_data = stk[$];
            3'd2, 3'd3: if (stk.size() < 2) e_err = 1'b1;
                  else begin
                      a = stk.pop_back();
                      b = stk.pop_back();
                      e_data = (op == 3'd2) ? b + a : b - a;
                      e_waddr = 4'(stk.size());
                      e_wr = 1;
                      stk.push_back(e_data);
                  end
            default: e_err = 1'b1;
        endcase
        e_lat = e_err ? 1 : (op == 3'd0) ? 2 : (op == 3'd1 || op == 3'd4) ? 3 : 5;
        if (h_len > 0 && h_at >= 1 && h_at <= e_lat)
            e_lat += h_len;
        if (!e_err) begin
            m_zero = (e_data == 8'h00);
            m_sign = e_data[7];
        end

        @(negedge clk);
        haltN = 1'b1; cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        #1 chk("cmd_ready", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_data = 8'($urandom);
        lat = 0; wr_n = 0; ok = 1'b0; g_data = '0; g_err = 1'b0;
        for (int k = 1; k <= 40 && !ok; k++) begin
            if (k > 1) @(negedge clk);
            haltN = !(h_len > 0 && k >= h_at && k < h_at + h_len);
            #1;
            if (!haltN) begin
                chk("halt_we", mem_we, 0);
                chk("halt_valid", rsp_valid, 0);
            end
            if (mem_we) begin wr_n++; wa = mem_addr; wd = mem_wdata; end
            if (rsp_valid) begin ok = 1'b1; lat = k; g_data = rsp_data; g_err = rsp_err; end
        end
        haltN = 1'b1;
        chk("rsp_seen", ok, 1);
        chk("latency", lat, e_lat);
        chk("rsp_data", g_data, e_data);
        chk("rsp_err", g_err, e_err);
        chk("writes", wr_n, e_wr);
        if (e_wr == 1) begin
            chk("wr_addr", wa, e_waddr);
            chk("wr_data", wd, e_data);
        end
        last_data = g_data;
        @(posedge clk);
        #1;
        chk("valid_pulse", rsp_valid, 0);
        chk("count", count, stk.size());
        chk("empty", empty, stk.size() == 0);
        chk("full", full, stk.size() == 16);
        chk("zero_flag", zero_flag, m_zero);
        chk("sign_flag", sign_flag, m_sign);
    endtask

    initial begin
        int wr_n, n, r;
        logic [2:0] op;
        rstN = 1'b0; haltN = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
        m_zero = 1'b0; m_sign = 1'b0; last_data = '0;
        for (int i = 0; i < 16; i++) ram[i] = 8'hAA;

        // Reset asserted while frozen: reset must still win
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_zero", zero_flag, 0);
        chk("rst_sign", sign_flag, 0);
        haltN = 1'b1; rstN = 1'b1;

        run_cmd(3'd0, 8'h05, 0, 0); chk("plan_push5", last_data, 8'h05);
        run_cmd(3'd0, 8'h03, 0, 0); chk("plan_push3", last_data, 8'h03);
        chk("plan_ram0", ram[0], 8'h05);
        chk("plan_ram1", ram[1], 8'h03);
        run_cmd(3'd3, 8'h00, 0, 0); chk("plan_sub", last_data, 8'h02);
        chk("plan_ram0b", ram[0], 8'h02);
        run_cmd(3'd0, 8'h02, 0, 0);
        run_cmd(3'd3, 8'h00, 0, 0); chk("plan_zero", zero_flag, 1);
        run_cmd(3'd0, 8'h03, 0, 0);
        run_cmd(3'd0, 8'h05, 0, 0);
        run_cmd(3'd3, 8'h00, 0, 0); chk("plan_neg", last_data, 8'hFE);
        chk("plan_sign", sign_flag, 1);
        run_cmd(3'd0, 8'h03, 0, 0);
        run_cmd(3'd2, 8'h00, 0, 0); chk("plan_wrap", last_data, 8'h01);

        while (stk.size() > 0) run_cmd(3'd1, 8'h00, 0, 0);
        for (int i = 0; i < 16; i++) run_cmd(3'd0, 8'($urandom), 0, 0);
        chk("plan_full", full, 1);
        run_cmd(3'd0, 8'h99, 0, 0);
        for (int i = 0; i < 16; i++) run_cmd(3'd1, 8'h00, 0, 0);
        run_cmd(3'd1, 8'h00, 0, 0);
        run_cmd(3'd0, 8'h44, 0, 0);
        run_cmd(3'd2, 8'h00, 0, 0);
        run_cmd(3'd6, 8'h00, 0, 0);
        run_cmd(3'd1, 8'h00, 0, 0);
        run_cmd(3'd0, 8'h7A, 0, 0);
        run_cmd(3'd4, 8'h00, 0, 0); chk("plan_top", last_data, 8'h7A);
        run_cmd(3'd1, 8'h00, 0, 0); chk("plan_pop", last_data, 8'h7A);

        // Freeze during WR of ADD and of PUSH
        run_cmd(3'd0, 8'h10, 0, 0);
        run_cmd(3'd0, 8'h20, 0, 0);
        run_cmd(3'd2, 8'h00, 4, 3);
        run_cmd(3'd0, 8'h31, 1, 2);

        // Reset during GET_B of an ADD abandons it without a write
        run_cmd(3'd0, 8'h11, 0, 0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_data = '0;
        #1 chk("rstmid_ready", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wr_n = 0;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) @(negedge clk);
            #1 if (mem_we) wr_n++;
        end
        rstN = 1'b0;
        #1;
        chk("rstmid_we", mem_we, 0);
        chk("rstmid_ready0", cmd_ready, 0);
        chk("rstmid_count0", count, 0);
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        if (mem_we) wr_n++;
        chk("rstmid_count", count, 0);
        chk("rstmid_valid", rsp_valid, 0);
        chk("rstmid_idle", cmd_ready, 1);
        @(negedge clk);
        #1 if (mem_we) wr_n++;
        chk("rstmid_nowrite", wr_n, 0);
        chk("rstmid_zero", zero_flag, 0);
        stk.delete(); m_zero = 1'b0; m_sign = 1'b0;

        // Randomized commands with occasional freezes
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 9: op = 3'd0;
                3, 4:       op = 3'd1;
                5:          op = 3'd4;
                6:          op = 3'd2;
                7:          op = 3'd3;
                default:    op = 3'($urandom_range(5, 7));
            endcase
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run_cmd(op, 8'($urandom), $urandom_range(1, 5), n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
